// File: rtl/bytewrite_ram_sdp_pkg.sv
// Shared types and parameter limits for the byte-write simple-dual-port RAM.
package bytewrite_ram_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rdw_mode_e;

    localparam int unsigned LAT_MIN   = 1;
    localparam int unsigned LAT_MAX   = 2;
    localparam int unsigned BW_NARROW = 8;
    localparam int unsigned BW_PARITY = 9;

    function automatic bit lat_ok(input int unsigned lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

    function automatic bit bw_ok(input int unsigned bw);
        return (bw == BW_NARROW) || (bw == BW_PARITY);
    endfunction

endpackage

// File: rtl/bytewrite_ram_sdp_if.sv
// Write port and read port of the byte-write RAM, with requester/RAM views.
interface bytewrite_ram_sdp_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned NB = 4,
    parameter int unsigned BW = 8
);
    localparam int unsigned DW = NB * BW;

    logic          wr_en;
    logic [NB-1:0] wr_be;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          coll;

    modport master (
        output wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_valid, rd_data, coll
    );

    modport slave (
        input  wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
        output rd_valid, rd_data, coll
    );

endinterface

// File: rtl/bytewrite_ram_sdp_lane_merge.sv
// Per-lane select between the stored word and the incoming write word.
module bytewrite_lane_merge #(
    parameter int unsigned NB = 4,
    parameter int unsigned BW = 8
) (
    input  logic [NB*BW-1:0] old_i,
    input  logic [NB*BW-1:0] new_i,
    input  logic [NB-1:0]    be_i,
    output logic [NB*BW-1:0] merged_o
);

    for (genvar i = 0; i < NB; i++) begin : g_lane
        always_comb begin
            merged_o[i*BW +: BW] = be_i[i] ? new_i[i*BW +: BW] : old_i[i*BW +: BW];
        end
    end

endmodule

// File: rtl/bytewrite_ram_sdp.sv
// Simple-dual-port RAM with per-lane write enables and a valid-qualified read pipeline.
// Read latency (1 or 2) and read-during-write policy are selected by parameters.
module bytewrite_ram_sdp
    import bytewrite_ram_pkg::*;
#(
    parameter int unsigned AW            = 10,
    parameter int unsigned NB            = 4,
    parameter int unsigned BW            = 8,
    parameter int unsigned READ_LAT      = 1,
    parameter rdw_mode_e   RDW_MODE      = READ_FIRST,
    parameter string       RAM_STYLE_VAL = "block"
) (
    input  logic               clk,
    input  logic               rst,
    bytewrite_ram_sdp_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** AW;

    if (!lat_ok(READ_LAT)) begin : g_bad_lat
        $error("bytewrite_ram_sdp: READ_LAT must be 1 or 2, got %0d", READ_LAT);
    end
    if (!bw_ok(BW)) begin : g_bad_bw
        $error("bytewrite_ram_sdp: BW must be 8 or 9, got %0d", BW);
    end
    if (RAM_STYLE_VAL == "") begin : g_bad_style
        $error("bytewrite_ram_sdp: RAM_STYLE_VAL must not be empty");
    end

    typedef logic [NB-1:0][BW-1:0] word_t;

    (* ram_style = RAM_STYLE_VAL *)
    word_t mem_q [DEPTH];

    logic  wr_go;
    logic  hit;
    word_t old_word;
    word_t rd_word;

    logic  s1_valid_q, s1_valid_d;
    logic  s1_coll_q,  s1_coll_d;
    word_t s1_data_q,  s1_data_d;

    logic  out_valid;
    logic  out_coll;
    word_t out_data;

    // Reset gates the write enable through a combinational term so the array stays reset-free.
    always_comb begin
        wr_go = bus.wr_en && !rst;
    end

    for (genvar i = 0; i < NB; i++) begin : g_wr_lane
        always_ff @(posedge clk) begin
            if (wr_go && bus.wr_be[i]) begin
                mem_q[bus.wr_addr][i] <= bus.wr_data[i*BW +: BW];
            end
        end
    end

    always_comb begin
        old_word = mem_q[bus.rd_addr];
        hit      = bus.rd_en && bus.wr_en && (bus.rd_addr == bus.wr_addr) && (|bus.wr_be);
    end

    if (RDW_MODE == WRITE_FIRST) begin : g_write_first
        logic [NB-1:0] hit_be;

        always_comb begin
            hit_be = hit ? bus.wr_be : '0;
        end

        bytewrite_lane_merge #(
            .NB (NB),
            .BW (BW)
        ) u_merge (
            .old_i    (old_word),
            .new_i    (bus.wr_data),
            .be_i     (hit_be),
            .merged_o (rd_word)
        );
    end else begin : g_read_first
        always_comb begin
            rd_word = old_word;
        end
    end

    always_comb begin
        s1_valid_d = bus.rd_en;
        s1_coll_d  = hit;
        s1_data_d  = s1_data_q;
        if (bus.rd_en) begin
            s1_data_d = rd_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_coll_q  <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_coll_q  <= s1_coll_d;
            s1_data_q  <= s1_data_d;
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic  s2_valid_q, s2_valid_d;
        logic  s2_coll_q,  s2_coll_d;
        word_t s2_data_q,  s2_data_d;

        // Output register only loads on a valid stage-1 beat so rd_data holds between reads.
        always_comb begin
            s2_valid_d = s1_valid_q;
            s2_coll_d  = s1_coll_q;
            s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_valid_q <= 1'b0;
                s2_coll_q  <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_coll_q  <= s2_coll_d;
                s2_data_q  <= s2_data_d;
            end
        end

        always_comb begin
            out_valid = s2_valid_q;
            out_coll  = s2_coll_q;
            out_data  = s2_data_q;
        end
    end else begin : g_lat1
        always_comb begin
            out_valid = s1_valid_q;
            out_coll  = s1_coll_q;
            out_data  = s1_data_q;
        end
    end

    always_comb begin
        bus.rd_valid = out_valid;
        bus.coll     = out_coll;
        bus.rd_data  = out_data;
    end

endmodule

// File: tb/tb_bytewrite_ram_sdp.sv
// Scoreboard bench: two instances (latency 1 read-first, latency 2 write-first) share stimulus.
module tb_bytewrite_ram_sdp;
    import bytewrite_ram_pkg::*;

    localparam int unsigned AW    = 10;
    localparam int unsigned NB    = 4;
    localparam int unsigned BW    = 8;
    localparam int unsigned DW    = NB * BW;
    localparam int unsigned DEPTH = 2 ** AW;

    typedef struct {
        logic [DW-1:0] data;
        logic          coll;
        int unsigned   cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic [DW-1:0] model [DEPTH];
    exp_t          expq [2][$];
    logic [DW-1:0] last_data [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bytewrite_ram_sdp_if #(.AW(AW), .NB(NB), .BW(BW)) if_a ();
    bytewrite_ram_sdp_if #(.AW(AW), .NB(NB), .BW(BW)) if_b ();

    bytewrite_ram_sdp #(
        .AW(AW), .NB(NB), .BW(BW), .READ_LAT(1),
        .RDW_MODE(READ_FIRST), .RAM_STYLE_VAL("block")
    ) dut_a (.clk(clk), .rst(rst), .bus(if_a));

    bytewrite_ram_sdp #(
        .AW(AW), .NB(NB), .BW(BW), .READ_LAT(2),
        .RDW_MODE(WRITE_FIRST), .RAM_STYLE_VAL("block")
    ) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    task automatic set_inputs(input logic we, input logic [NB-1:0] be, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        if_a.wr_en = we; if_a.wr_be = be; if_a.wr_addr = wa; if_a.wr_data = wd;
        if_a.rd_en = re; if_a.rd_addr = ra;
        if_b.wr_en = we; if_b.wr_be = be; if_b.wr_addr = wa; if_b.wr_data = wd;
        if_b.rd_en = re; if_b.rd_addr = ra;
    endtask

    // One bus cycle: present inputs, predict both read responses, then commit the write to the model.
    task automatic drive(input logic we, input logic [NB-1:0] be, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        logic [DW-1:0] old, wf;
        logic          same;
        exp_t          e;
        @(posedge clk);
        #1;
        set_inputs(we, be, wa, wd, re, ra);
        if (!rst) begin
            old  = model[ra];
            same = re && we && (wa == ra) && (be != '0);
            if (re) begin
                wf = old;
                for (int unsigned l = 0; l < NB; l++) begin
                    if (same && be[l]) wf[l*BW +: BW] = wd[l*BW +: BW];
                end
                e.data = old; e.coll = same; e.cyc = cyc + 1;
                expq[0].push_back(e);
                e.data = wf;  e.coll = same; e.cyc = cyc + 2;
                expq[1].push_back(e);
            end
            if (we) begin
                for (int unsigned l = 0; l < NB; l++) begin
                    if (be[l]) model[wa][l*BW +: BW] = wd[l*BW +: BW];
                end
            end
        end
    endtask

    task automatic do_reset(input int unsigned n, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        @(posedge clk);
        #1;
        set_inputs(1'b1, '1, addr, wd, 1'b1, addr);
        rst = 1'b1;
        expq[0].delete();
        expq[1].delete();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        set_inputs(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic check_port(input int p, input logic v, input logic [DW-1:0] d, input logic c);
        exp_t e;
        string nm;
        nm = (p == 0) ? "lat1_rf" : "lat2_wf";
        checks++;
        if (rst) begin
            last_data[p] = '0;
            if (v !== 1'b0 || d !== '0 || c !== 1'b0) begin
                failures++;
                $display("FAIL reset_%s: got valid=%b data=%h coll=%b, want 0/0/0", nm, v, d, c);
            end
        end else if (v === 1'b1) begin
            if (expq[p].size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid_%s: got data=%h coll=%b at cyc %0d, want no valid", nm, d, c, cyc);
            end else begin
                e = expq[p].pop_front();
                last_data[p] = e.data;
                if (d !== e.data || c !== e.coll || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL read_%s: got data=%h coll=%b cyc=%0d, want data=%h coll=%b cyc=%0d",
                             nm, d, c, cyc, e.data, e.coll, e.cyc);
                end
            end
        end else begin
            if (v !== 1'b0 || d !== last_data[p] || c !== 1'b0) begin
                failures++;
                $display("FAIL hold_%s: got valid=%b data=%h coll=%b, want 0/%h/0", nm, v, d, c, last_data[p]);
            end
        end
    endtask

    always @(negedge clk) begin
        check_port(0, if_a.rd_valid, if_a.rd_data, if_a.coll);
        check_port(1, if_b.rd_valid, if_b.rd_data, if_b.coll);
    end

    initial begin
        last_data[0] = '0;
        last_data[1] = '0;
        for (int unsigned i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset held with read and write requests active.
        set_inputs(1'b1, '1, 10'h005, 32'hDEADBEEF, 1'b1, 10'h005);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        set_inputs(1'b0, '0, '0, '0, 1'b0, '0);

        for (int unsigned a = 0; a < DEPTH; a++) drive(1'b1, '1, AW'(a), '0, 1'b0, '0);

        // Partial lane write then full-word read.
        drive(1'b1, 4'hF, 10'h010, 32'hAABBCCDD, 1'b0, '0);
        drive(1'b1, 4'h5, 10'h010, 32'h11223344, 1'b0, '0);
        drive(1'b0, 4'h0, '0, '0, 1'b1, 10'h010);
        drive(1'b0, 4'h0, '0, '0, 1'b0, '0);

        // Same-address collisions, full and partial lanes.
        drive(1'b1, 4'hF, 10'h020, 32'hFFFFFFFF, 1'b1, 10'h020);
        drive(1'b0, 4'h0, '0, '0, 1'b1, 10'h020);
        drive(1'b1, 4'hF, 10'h020, 32'h12345678, 1'b0, '0);
        drive(1'b1, 4'h9, 10'h020, 32'hAAAAAAAA, 1'b1, 10'h020);
        drive(1'b0, 4'h0, '0, '0, 1'b1, 10'h020);
        repeat (3) drive(1'b0, 4'h0, '0, '0, 1'b0, '0);

        // Streaming reads with zero-lane writes alongside.
        for (int unsigned a = 0; a < 16; a++) drive(1'b1, 4'hF, AW'(a), 32'hC0DE0000 + a * 32'h111, 1'b0, '0);
        for (int unsigned a = 0; a < 16; a++) drive(1'b1, 4'h0, AW'(a), $urandom, 1'b1, AW'(a));
        repeat (3) drive(1'b0, 4'h0, '0, '0, 1'b0, '0);

        // Random traffic on a narrow address window to provoke collisions.
        for (int unsigned n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), NB'($urandom), AW'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));
        end
        repeat (3) drive(1'b0, 4'h0, '0, '0, 1'b0, '0);

        // Reset pulse while a read is in flight; blocked write must not disturb memory.
        drive(1'b1, 4'hF, 10'h030, 32'h5A5AA5A5, 1'b0, '0);
        drive(1'b0, 4'h0, '0, '0, 1'b1, 10'h030);
        do_reset(1, 10'h030, 32'h00000000);
        repeat (3) drive(1'b0, 4'h0, '0, '0, 1'b0, '0);
        drive(1'b0, 4'h0, '0, '0, 1'b1, 10'h030);
        drive(1'b0, 4'h0, '0, '0, 1'b1, 10'h010);
        repeat (4) drive(1'b0, 4'h0, '0, '0, 1'b0, '0);

        for (int p = 0; p < 2; p++) begin
            checks++;
            if (expq[p].size() != 0) begin
                failures++;
                $display("FAIL drain_port%0d: got %0d responses outstanding, want 0", p, expq[p].size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
